nes_cmd_bridge: RTL

//   Consumes the 32-bit command word written by the PS into AXI-Lite register 0 (value).

---
 rtl/nes_cmd_bridge_pkg.sv | 39 +++
 rtl/nes_cmd_bridge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/nes_cmd_bridge_pkg.sv
// nes_cmd_bridge_pkg
//   Shared definitions for the NES command bridge: opcode values, FSM state
//   encodings and bit positions inside the result status word. Kept in one
//   place so the PS driver header generator and the RTL agree on the layout.
package nes_cmd_bridge_pkg;

    // Command word layout: [31]=seq toggle, [30:28]=opcode, [27:0]=arg
    localparam int CMD_SEQ_BIT = 31;
    localparam int CMD_OP_HI   = 30;
    localparam int CMD_OP_LO   = 28;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_SET_ADDR   = 3'd1,
        OP_WRITE_BYTE = 3'd2,
        OP_SET_JOY    = 3'd3,
        OP_NES_RST    = 3'd4
    } nes_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } nes_state_e;

    // Result word layout
    localparam int RES_ACK_BIT  = 31;
    localparam int RES_BUSY_BIT = 30;
    localparam int RES_ERR_BIT  = 29;
    localparam int RES_OP_HI    = 28;
    localparam int RES_OP_LO    = 26;
    localparam int RES_ADDR_W   = 22;

    // Legal opcodes are 0..4; 5..7 are reserved and flagged as errors.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'd4);
    endfunction

endpackage

// File: rtl/nes_cmd_bridge.sv
// nes_cmd_bridge
//   Decodes the 32-bit command word written by the PS into AXI-Lite
//   register 0 and drives the ROM loader write port, joypad state and NES
//   reset. Handshake and status come back in the result word (register 1).
//   A command is pending whenever the registered seq toggle differs from the
//   last acknowledged toggle; toggle flips while busy are not sampled.
//
// Ports
//   clk              system clock (AXI-Lite ACLK domain)
//   reset            asynchronous active-high reset
//   value[31:0]      command word from AXI register 0
//   result[31:0]     {ack, busy, err, last_op[2:0], 4'b0, addr[21:0]}
//   loader_wr_valid  loader write request, held until loader_wr_ready
//   loader_wr_ready  loader accepts write
//   loader_addr      loader byte address (auto-increments after each write)
//   loader_data      loader byte data
//   joy1, joy2       joypad button bits
//   nes_reset        holds NES core in reset (1 after reset)
//
// Configuration
//   NES_CMD_TIMEOUT_EN  when defined, a WRITE_BYTE that sees no ready for
//                       TIMEOUT_CYCLES cycles is abandoned with err set; the
//                       command is still acknowledged and addr is unchanged.
module nes_cmd_bridge
    import nes_cmd_bridge_pkg::*;
#(
    parameter int ADDR_W         = 22,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       value,
    output logic [31:0]       result,
    output logic              loader_wr_valid,
    input  logic              loader_wr_ready,
    output logic [ADDR_W-1:0] loader_addr,
    output logic [7:0]        loader_data,
    output logic [7:0]        joy1,
    output logic [7:0]        joy2,
    output logic              nes_reset
);

    nes_state_e        state;
    logic [31:0]       cmd_q;
    logic [31:0]       cmd_r;
    logic              ack_q;
    logic              busy;
    logic              err;
    logic [2:0]        last_op;
    logic [ADDR_W-1:0] addr;

`ifdef NES_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]  cnt;
`endif

    logic [2:0] op_r;
    assign op_r = cmd_r[CMD_OP_HI:CMD_OP_LO];

    // Address only moves on a completed handshake, so it is stable for the
    // whole time valid is held.
    assign loader_addr = addr;

    assign result = {ack_q, busy, err, last_op, 4'b0000, RES_ADDR_W'(addr)};

    // Arg bits above the loader address width are never consumed.
    logic unused_arg;
    assign unused_arg = ^cmd_r[27:ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            cmd_q           <= '0;
            cmd_r           <= '0;
            ack_q           <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b0;
            last_op         <= '0;
            addr            <= '0;
            loader_wr_valid <= 1'b0;
            loader_data     <= '0;
            joy1            <= '0;
            joy2            <= '0;
            nes_reset       <= 1'b1;
`ifdef NES_CMD_TIMEOUT_EN
            cnt             <= '0;
`endif
        end else begin
            cmd_q <= value;
            case (state)
                ST_IDLE: begin
                    if (cmd_q[CMD_SEQ_BIT] != ack_q) begin
                        cmd_r <= cmd_q;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                        // Raise the write request on EXEC entry so valid is
                        // registered and visible for the first EXEC cycle.
                        if (cmd_q[CMD_OP_HI:CMD_OP_LO] == OP_WRITE_BYTE) begin
                            loader_wr_valid <= 1'b1;
                            loader_data     <= cmd_q[7:0];
                        end
`ifdef NES_CMD_TIMEOUT_EN
                        cnt <= '0;
`endif
                    end
                end

                ST_EXEC: begin
                    case (op_r)
                        OP_NOP: begin
                            err   <= 1'b0;
                            state <= ST_DONE;
                        end
                        OP_SET_ADDR: begin
                            addr  <= cmd_r[ADDR_W-1:0];
                            err   <= 1'b0;
                            state <= ST_DONE;
                        end
                        OP_SET_JOY: begin
                            joy1  <= cmd_r[7:0];
                            joy2  <= cmd_r[15:8];
                            err   <= 1'b0;
                            state <= ST_DONE;
                        end
                        OP_NES_RST: begin
                            nes_reset <= cmd_r[0];
                            err       <= 1'b0;
                            state     <= ST_DONE;
                        end
                        OP_WRITE_BYTE: begin
                            if (loader_wr_ready) begin
                                loader_wr_valid <= 1'b0;
                                addr            <= addr + 1'b1;
                                err             <= 1'b0;
                                state           <= ST_DONE;
                            end
`ifdef NES_CMD_TIMEOUT_EN
                            else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                                loader_wr_valid <= 1'b0;
                                err             <= 1'b1;
                                state           <= ST_DONE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
`endif
                        end
                        default: begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end
                    endcase
                end

                ST_DONE: begin
                    ack_q   <= cmd_r[CMD_SEQ_BIT];
                    last_op <= op_r;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
